xor_word_packer: RTL and testbench



---
 rtl/xor_word_packer_if.sv | 42 ++++
 rtl/xor_word_packer.sv | 89 ++++++++
 tb/tb_xor_word_packer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/xor_word_packer_if.sv
// Handshake bundle for xor_word_packer: narrow beat input side and packed-word output side.
// Optional parity-check signals exist only with XOR_WORD_PACKER_PARITY_CHECK_EN.
interface xor_word_packer_if #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
);
  localparam int BEATS = WIDTH / CHUNK;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [CHUNK-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic             out_parity;
  logic [CW-1:0]    beat_cnt;
`ifdef XOR_WORD_PACKER_PARITY_CHECK_EN
  logic             exp_parity;
  logic             parity_err;
  logic [7:0]       err_cnt;
`endif

  modport slave (
    input  in_valid, in_data, flush, out_ready,
`ifdef XOR_WORD_PACKER_PARITY_CHECK_EN
    input  exp_parity,
    output parity_err, err_cnt,
`endif
    output in_ready, out_valid, out_word, out_parity, beat_cnt
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
`ifdef XOR_WORD_PACKER_PARITY_CHECK_EN
    output exp_parity,
    input  parity_err, err_cnt,
`endif
    input  in_ready, out_valid, out_word, out_parity, beat_cnt
  );
endinterface

// File: rtl/xor_word_packer.sv
// Packs CHUNK-bit beats LSB-first into WIDTH-bit words with running XOR parity and a
// one-entry registered output. XOR_WORD_PACKER_PARITY_CHECK_EN adds parity_err/err_cnt.
module xor_word_packer #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic            clk,
  input logic            rst_n,
  xor_word_packer_if.slave bus
);
  localparam int BEATS = WIDTH / CHUNK;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic             parity;
  } out_t;

  logic [WIDTH-1:0] acc, merged;
  logic             run_par, par_next;
  logic [CW-1:0]    cnt;
  out_t             out_q;
  logic             out_vld;
  logic             is_final, accept, load;

  assign is_final = (cnt == CW'(BEATS - 1));
  // Only the final beat needs room in the output register; earlier beats never stall.
  assign bus.in_ready = is_final ? (!out_vld || bus.out_ready) : 1'b1;
  assign accept   = bus.in_valid && bus.in_ready;
  assign load     = accept && is_final && !bus.flush;
  assign par_next = run_par ^ (^bus.in_data);

  for (genvar k = 0; k < BEATS; k++) begin : g_slice
    assign merged[k*CHUNK +: CHUNK] = (cnt == CW'(k)) ? bus.in_data : acc[k*CHUNK +: CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      run_par <= 1'b0;
      cnt     <= '0;
      out_q   <= '0;
      out_vld <= 1'b0;
    end else begin
      if (bus.flush || (accept && is_final)) begin
        acc     <= '0;
        run_par <= 1'b0;
        cnt     <= '0;
      end else if (accept) begin
        acc     <= merged;
        run_par <= par_next;
        cnt     <= cnt + CW'(1);
      end
      // A reload on the same cycle as a drain keeps out_valid high.
      if (load) begin
        out_q   <= '{word: merged, parity: par_next};
        out_vld <= 1'b1;
      end else if (out_vld && bus.out_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_vld;
  assign bus.out_word   = out_q.word;
  assign bus.out_parity = out_q.parity;
  assign bus.beat_cnt   = cnt;

`ifdef XOR_WORD_PACKER_PARITY_CHECK_EN
  logic       perr;
  logic [7:0] ecnt;
  logic       mismatch;

  assign mismatch = par_next != bus.exp_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr <= 1'b0;
      ecnt <= '0;
    end else if (load) begin
      perr <= mismatch;
      if (mismatch && ecnt != 8'hFF) ecnt <= ecnt + 8'd1;
    end
  end

  assign bus.parity_err = perr;
  assign bus.err_cnt    = ecnt;
`endif
endmodule

// File: tb/tb_xor_word_packer.sv
// Directed bench for xor_word_packer; expected words are queued by the driver and
// checked by a negedge monitor whenever the output handshake completes.
module tb_xor_word_packer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xor_word_packer_if #(.WIDTH(32), .CHUNK(4)) bus ();
  xor_word_packer #(.WIDTH(32), .CHUNK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [31:0] w;
    logic        p;
  } exp_t;
  exp_t q[$];

  int n_pass = 0, n_total = 0, stalls = 0, vcount = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst_n && bus.out_valid) vcount++;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_word", bus.out_word, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_word", bus.out_word, e.w);
        check("out_parity", {31'd0, bus.out_parity}, {31'd0, e.p});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat's accepting edge.
  task automatic send(input logic [3:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd0, 32'd1);
    if (n > 0) stalls++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic p, input logic e);
    exp_t x;
`ifdef XOR_WORD_PACKER_PARITY_CHECK_EN
    bus.exp_parity = e;
`else
    if (e !== p) stalls = stalls;
`endif
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        x.w = w; x.p = p;
        q.push_back(x);
      end
      send(w[k*4 +: 4]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t x;
    int c0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
`ifdef XOR_WORD_PACKER_PARITY_CHECK_EN
    bus.exp_parity = 1'b0;
`endif
    #2;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_word", bus.out_word, 32'd0);
    check("rst_out_parity", {31'd0, bus.out_parity}, 32'd0);
    check("rst_beat_cnt", {29'd0, bus.beat_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single word, one-cycle latency, out_valid for exactly one cycle
    vcount = 0;
    send_word(32'h87654321, 1'b1, 1'b1);
    check("t1_latency", {31'd0, bus.out_valid}, 32'd1);
    idle(1);
    check("t1_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    idle(2);
    check("t1_valid_cycles", vcount, 32'd1);

    // 2: back-to-back words with no bubbles
    stalls = 0;
    c0 = cyc;
    send_word(32'hFFFFFFFF, 1'b0, 1'b0);
    send_word(32'hFFFFFFFF, 1'b0, 1'b0);
    check("t2_cycles", cyc - c0, 32'd16);
    check("t2_stalls", stalls, 32'd0);
    idle(2);

    // 3: backpressure on the final beat
    bus.out_ready = 1'b0;
    send_word(32'h11111111, 1'b0, 1'b0);
    send(4'h7);
    for (int k = 1; k < 7; k++) send(4'h0);
`ifdef XOR_WORD_PACKER_PARITY_CHECK_EN
    bus.exp_parity = 1'b1;
`endif
    x.w = 32'h00000007; x.p = 1'b1;
    q.push_back(x);
    bus.in_valid = 1'b1; bus.in_data = 4'h0;
    #1;
    check("t3_ready_low", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    check("t3_beat_cnt", {29'd0, bus.beat_cnt}, 32'd7);
    check("t3_hold_word", bus.out_word, 32'h11111111);
    bus.out_ready = 1'b1;
    #1;
    check("t3_ready_high", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("t3_reload_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t3_reload_word", bus.out_word, 32'h00000007);
    idle(2);

    // 4: flush discards the partial word and the flush-cycle beat
    send(4'hA); send(4'hB); send(4'hC);
    bus.in_valid = 1'b1; bus.in_data = 4'hD; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("t4_flush_cnt", {29'd0, bus.beat_cnt}, 32'd0);
    send_word(32'h00000001, 1'b1, 1'b1);
    idle(2);

    // 5: asynchronous reset mid-word with a pending word
    bus.out_ready = 1'b0;
    send_word(32'h22222222, 1'b0, 1'b0);
    send(4'h3); send(4'h4); send(4'h5);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    check("t5_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_rst_cnt", {29'd0, bus.beat_cnt}, 32'd0);
    check("t5_rst_word", bus.out_word, 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send_word(32'h13579BDE, 1'b1, 1'b1);
    check("t5_fresh_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t5_fresh_word", bus.out_word, 32'h13579BDE);
    idle(2);

`ifdef XOR_WORD_PACKER_PARITY_CHECK_EN
    send_word(32'hFFFFFFFE, 1'b1, 1'b0);
    check("pc_err", {31'd0, bus.parity_err}, 32'd1);
    check("pc_cnt1", {24'd0, bus.err_cnt}, 32'd1);
    for (int i = 0; i < 300; i++) send_word(32'hFFFFFFFE, 1'b1, 1'b0);
    check("pc_sat", {24'd0, bus.err_cnt}, 32'd255);
    send_word(32'h00000003, 1'b0, 1'b0);
    check("pc_ok", {31'd0, bus.parity_err}, 32'd0);
    check("pc_hold", {24'd0, bus.err_cnt}, 32'd255);
`endif

    idle(3);
    check("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
